matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_loader.sv | 109 ++++++++++
 tb/tb_matrix_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Streams row-major 32-bit elements into a zero-padded WIDTH x WIDTH matrix
// and holds the result with a valid/ready handoff to the next stage.
`ifndef WIDTH_BIT
`define WIDTH_BIT 2
`endif

module matrix_loader #(
  parameter int unsigned WIDTH = 2 ** `WIDTH_BIT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [`WIDTH_BIT-1:0]                rows_m1,
  input  logic [`WIDTH_BIT-1:0]                cols_m1,
  input  logic                                 in_valid,
  input  logic [31:0]                          in_data,
  output logic                                 in_ready,
  output logic [0:WIDTH-1][0:WIDTH-1][31:0]    mat,
  output logic [0:1][`WIDTH_BIT-1:0]           size,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy
);

  localparam int unsigned IW = `WIDTH_BIT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]                            state_q, state_d;
  logic [IW-1:0]                         row_q, row_d;
  logic [IW-1:0]                         col_q, col_d;
  logic [0:1][IW-1:0]                    size_q, size_d;
  logic [0:WIDTH-1][0:WIDTH-1][31:0]     mat_q, mat_d;
  logic                                  in_ready_q, out_valid_q, busy_q;

  // Next-state, index advance and matrix write
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    size_d  = size_q;
    mat_d   = mat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          size_d[0] = rows_m1;
          size_d[1] = cols_m1;
          mat_d     = '0;
          row_d     = '0;
          col_d     = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          mat_d[row_q][col_q] = in_data;
          if (col_q == size_q[1]) begin
            col_d = '0;
            // Last element: park indices at zero instead of stepping past the bound
            if (row_q == size_q[0]) begin
              row_d   = '0;
              state_d = S_HOLD;
            end else begin
              row_d = row_q + IW'(1);
            end
          end else begin
            col_d = col_q + IW'(1);
          end
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      size_q      <= '0;
      mat_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      size_q      <= size_d;
      mat_q       <= mat_d;
      in_ready_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_HOLD);
      busy_q      <= (state_d == S_LOAD) || (state_d == S_HOLD);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign mat       = mat_q;
  assign size      = size_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with WIDTH_BIT=2 (4x4 storage).
`ifndef WIDTH_BIT
`define WIDTH_BIT 2
`endif

module tb_matrix_loader;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        start;
  logic [1:0]                  rows_m1;
  logic [1:0]                  cols_m1;
  logic                        in_valid;
  logic [31:0]                 in_data;
  logic                        in_ready;
  logic [0:3][0:3][31:0]       mat;
  logic [0:1][1:0]             size;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  logic [0:3][0:3][31:0]       exp_mat;
  logic [0:1][1:0]             exp_size;
  int                          checks = 0;
  int                          passed = 0;

  matrix_loader #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rows_m1   (rows_m1),
    .cols_m1   (cols_m1),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mat       (mat),
    .size      (size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rows_m1 = '0; cols_m1 = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready",  512'(in_ready),  512'(1'b0));
    check("rst_out_valid", 512'(out_valid), 512'(1'b0));
    check("rst_busy",      512'(busy),      512'(1'b0));
    check("rst_mat",       512'(mat),       512'(0));
    check("rst_size",      512'(size),      512'(0));
    rst_n = 1'b1;
    tick();

    // 2x3 load of 1..6 back-to-back
    start = 1'b1; rows_m1 = 2'd1; cols_m1 = 2'd2;
    tick();
    start = 1'b0;
    check("t1_busy",     512'(busy),     512'(1'b1));
    check("t1_in_ready", 512'(in_ready), 512'(1'b1));
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      tick();
      if (k == 5) check("t1_ov_early", 512'(out_valid), 512'(1'b0));
    end
    in_valid = 1'b0;
    exp_mat = '0;
    exp_mat[0][0] = 32'd1; exp_mat[0][1] = 32'd2; exp_mat[0][2] = 32'd3;
    exp_mat[1][0] = 32'd4; exp_mat[1][1] = 32'd5; exp_mat[1][2] = 32'd6;
    exp_size = {2'd1, 2'd2};
    check("t1_out_valid", 512'(out_valid), 512'(1'b1));
    check("t1_in_ready_hold", 512'(in_ready), 512'(1'b0));
    check("t1_mat",  512'(mat),  512'(exp_mat));
    check("t1_size", 512'(size), 512'(exp_size));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_idle_busy", 512'(busy),      512'(1'b0));
    check("t1_idle_ov",   512'(out_valid), 512'(1'b0));
    tick();
    check("t1_idle_retain", 512'(mat), 512'(exp_mat));

    // 4x4 load of 0..15 with a stall after every accept
    start = 1'b1; rows_m1 = 2'd3; cols_m1 = 2'd3;
    tick();
    start = 1'b0;
    check("t2_cleared", 512'(mat), 512'(0));
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      tick();
      in_valid = 1'b0; in_data = 32'hBAD0_BAD0;
      if (k == 15) check("t2_ov_latency", 512'(out_valid), 512'(1'b1));
      tick();
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_mat[i][j] = 32'(4 * i + j);
    exp_size = {2'd3, 2'd3};
    check("t2_mat",  512'(mat),  512'(exp_mat));
    check("t2_size", 512'(size), 512'(exp_size));

    // Hold for 10 cycles while start/in_valid are pulsed
    rows_m1 = 2'd0; cols_m1 = 2'd1; in_data = 32'h5555_5555;
    for (int c = 0; c < 10; c++) begin
      start = (c % 2 == 0); in_valid = (c % 3 == 0);
      tick();
      check("t3_hold_ov",   512'(out_valid), 512'(1'b1));
      check("t3_hold_mat",  512'(mat),       512'(exp_mat));
      check("t3_hold_size", 512'(size),      512'(exp_size));
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_release_busy", 512'(busy),      512'(1'b0));
    check("t3_release_ov",   512'(out_valid), 512'(1'b0));

    // 1x1 load, started on the first IDLE cycle after handoff
    start = 1'b1; rows_m1 = 2'd0; cols_m1 = 2'd0;
    tick();
    start = 1'b0;
    check("t4_busy",    512'(busy), 512'(1'b1));
    check("t4_cleared", 512'(mat),  512'(0));
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    exp_mat = '0;
    exp_mat[0][0] = 32'hDEAD_BEEF;
    check("t4_ov",   512'(out_valid), 512'(1'b1));
    check("t4_mat",  512'(mat),       512'(exp_mat));
    check("t4_size", 512'(size),      512'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 2x2 load aborted by reset after 3 accepts, then reloaded
    start = 1'b1; rows_m1 = 2'd1; cols_m1 = 2'd1;
    tick();
    start = 1'b0;
    for (int k = 7; k <= 9; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      tick();
    end
    check("t5_ov_partial", 512'(out_valid), 512'(1'b0));
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'd99;
    tick();
    check("t5_rst_in_ready",  512'(in_ready),  512'(1'b0));
    check("t5_rst_out_valid", 512'(out_valid), 512'(1'b0));
    check("t5_rst_busy",      512'(busy),      512'(1'b0));
    check("t5_rst_mat",       512'(mat),       512'(0));
    check("t5_rst_size",      512'(size),      512'(0));
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("t5_stays_idle", 512'(busy), 512'(1'b0));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 7; k <= 10; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      tick();
    end
    in_valid = 1'b0;
    exp_mat = '0;
    exp_mat[0][0] = 32'd7; exp_mat[0][1] = 32'd8;
    exp_mat[1][0] = 32'd9; exp_mat[1][1] = 32'd10;
    exp_size = {2'd1, 2'd1};
    check("t5_ov",   512'(out_valid), 512'(1'b1));
    check("t5_mat",  512'(mat),       512'(exp_mat));
    check("t5_size", 512'(size),      512'(exp_size));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_done_busy", 512'(busy), 512'(1'b0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
